fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/types.sv | 17 +
 rtl/sync_fifo.sv | 73 +++++++
 rtl/fetch_buffer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/types.sv
// Shared types for the instruction fetch buffer: fetch FSM states and fetch step.
package types;

   // Fetch sequencer states.
   //   ST_IDLE    : no request on the ROM bus (buffer full or just out of reset)
   //   ST_REQ     : request held on the ROM bus, response is pushed on ack
   //   ST_DISCARD : request held after a redirect, its response is dropped on ack
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_e;

   // Instructions are one word wide, so sequential fetch advances by 4 bytes.
   localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a synchronous flush. The head entry is read straight
// from storage, so a pushed entry becomes visible one cycle after the push.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == DEPTH_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // Flush wins over push and pop; overflow and underflow requests are ignored.
   assign do_push  = push && !full  && !flush;
   assign do_pop   = pop  && !empty && !flush;

   // Next pointer and occupancy values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are qualified by count so it needs no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: keeps at most one request in flight to the program
// ROM, queues {PC, instruction} pairs and flushes/restarts on a redirect.
module fetch_buffer
   import types::*;
#(
   parameter int                         DATA_IBUS_WIDTH = 32,
   parameter int                         ADDR_IBUS_WIDTH = 32,
   parameter int                         DEPTH           = 4,
   parameter logic [ADDR_IBUS_WIDTH-1:0] RESET_PC        = '0
) (
   input  logic                       i_Clock,
   input  logic                       i_Reset,
   output logic                       o_RomReq,
   output logic [ADDR_IBUS_WIDTH-1:0] o_RomAddr,
   input  logic                       i_RomAck,
   input  logic [DATA_IBUS_WIDTH-1:0] i_RomData,
   output logic                       o_InstValid,
   output logic [DATA_IBUS_WIDTH-1:0] o_Inst,
   output logic [ADDR_IBUS_WIDTH-1:0] o_InstPC,
   input  logic                       i_InstReady,
   input  logic                       i_Redirect,
   input  logic [ADDR_IBUS_WIDTH-1:0] i_RedirectAddr
);

   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = ADDR_IBUS_WIDTH + DATA_IBUS_WIDTH;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   fetch_state_e               state_q, state_d;
   logic [ADDR_IBUS_WIDTH-1:0] addr_q, addr_d;   // fetch PC, driven as the ROM address
   logic [ADDR_IBUS_WIDTH-1:0] pend_q, pend_d;   // redirect target waiting out a DISCARD

   logic                       fifo_push;
   logic                       fifo_pop;
   logic [ENTRY_W-1:0]         fifo_wdata;
   logic [ENTRY_W-1:0]         fifo_rdata;
   logic [CNT_W-1:0]           fifo_count;
   logic [CNT_W-1:0]           cnt_after;
   logic                       fifo_full;
   logic                       fifo_empty;

   // A redirect flushes the queue, so a same-cycle pop is moot and suppressed.
   assign fifo_pop   = !fifo_empty && i_InstReady && !i_Redirect;
   assign fifo_wdata = {addr_q, i_RomData};
   assign cnt_after  = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);

   // Fetch sequencer: next state, next fetch PC and queue push.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      pend_d    = pend_q;
      fifo_push = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_Redirect) begin
               state_d = ST_REQ;
               addr_d  = i_RedirectAddr;
            end else if (!fifo_full) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (i_Redirect) begin
               if (i_RomAck) begin
                  // Response arrives with the redirect: drop it, restart at once.
                  addr_d = i_RedirectAddr;
               end else begin
                  // Keep the request stable until the ROM answers it.
                  state_d = ST_DISCARD;
                  pend_d  = i_RedirectAddr;
               end
            end else if (i_RomAck) begin
               fifo_push = 1'b1;
               addr_d    = addr_q + ADDR_IBUS_WIDTH'(INST_BYTES);
               state_d   = (cnt_after < DEPTH_CNT) ? ST_REQ : ST_IDLE;
            end
         end
         ST_DISCARD: begin
            if (i_RomAck) begin
               state_d = ST_REQ;
               addr_d  = i_Redirect ? i_RedirectAddr : pend_q;
            end else if (i_Redirect) begin
               pend_d = i_RedirectAddr;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer state and address registers.
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         state_q <= ST_IDLE;
         addr_q  <= RESET_PC;
         pend_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pend_q  <= pend_d;
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (i_Clock),
      .rst_n     (i_Reset),
      .flush     (i_Redirect),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign o_RomReq    = (state_q != ST_IDLE);
   assign o_RomAddr   = addr_q;
   assign o_InstValid = !fifo_empty;

   // Head entry is forced to zero while the queue is empty (including reset).
   always_comb begin
      o_Inst   = '0;
      o_InstPC = '0;
      if (!fifo_empty) begin
         o_Inst   = fifo_rdata[DATA_IBUS_WIDTH-1:0];
         o_InstPC = fifo_rdata[ENTRY_W-1:DATA_IBUS_WIDTH];
      end
   end

endmodule
